// File: rtl/layer_buf_bank.sv
// ---------------------------------------------------------------------------
// layer_buf_bank
// Multi-channel feature-map buffer. A serial load fills CH channels of
// IMG_W*IMG_W signed words, channel by channel. A scan then streams out one
// address per beat with all channels side by side. The scan covers either
// the first scan_len addresses or a zero-padded (IMG_W+2)^2 raster with a
// one-pixel border of zeros.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   load_start          : pulse in IDLE that starts a serial load
//   ld_valid / ld_data  : load word stream (signed DW bits)
//   ld_ready            : high while the bank accepts load words
//   ld_done             : one-cycle pulse after the last load word
//   scan_start          : pulse in IDLE that starts a read scan
//   scan_len / pad_en   : beat count and padding mode, sampled at scan_start
//   rd_valid / rd_ready : output handshake
//   rd_data             : CH*DW bits, channel 0 in the LSBs
//   rd_last             : marks the final beat of a scan
//   scan_done           : one-cycle pulse after the final beat is accepted
//   busy                : high whenever a load or scan is in progress
// ---------------------------------------------------------------------------
module layer_buf_bank #(
    parameter int DW    = 16,
    parameter int CH    = 6,
    parameter int IMG_W = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_start,
    input  logic                              ld_valid,
    input  logic signed [DW-1:0]              ld_data,
    output logic                              ld_ready,
    output logic                              ld_done,
    input  logic                              scan_start,
    input  logic [$clog2(IMG_W*IMG_W):0]      scan_len,
    input  logic                              pad_en,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [CH*DW-1:0]                  rd_data,
    output logic                              rd_last,
    output logic                              scan_done,
    output logic                              busy
);

    localparam int DEPTH = IMG_W * IMG_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW    = IMG_W + 2;
    localparam int NPAD  = PW * PW;
    localparam int BW    = $clog2(NPAD + 1);
    localparam int RW    = $clog2(PW);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(CH - 1);
    localparam logic [RW-1:0] EDGE_RC   = RW'(IMG_W + 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [BW-1:0] NPAD_B    = BW'(NPAD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       ch_cnt_r;
    logic [AW-1:0]       addr_cnt_r;
    logic                pad_r;
    logic [BW-1:0]       total_r;
    logic [BW-1:0]       issued_r;
    logic [RW-1:0]       row_r;
    logic [RW-1:0]       col_r;
    logic                ld_ready_r;
    logic                ld_done_r;
    logic                rd_valid_r;
    logic [CH*DW-1:0]    rd_data_r;
    logic                rd_last_r;
    logic                scan_done_r;
    logic                busy_r;

    logic [DW-1:0]       mem_r [CH][DEPTH];

    logic [LW-1:0]       len_norm_s;
    logic                on_edge_s;
    logic [AW-1:0]       rd_addr_s;
    logic [CH*DW-1:0]    beat_word_s;
    logic [CH*DW-1:0]    beat_data_s;
    logic                load_beat_s;
    logic                final_beat_s;
    logic                wr_en_s;

    assign ld_ready  = ld_ready_r;
    assign ld_done   = ld_done_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign rd_last   = rd_last_r;
    assign scan_done = scan_done_r;
    assign busy      = busy_r;

    // Unpadded scan length: zero or anything past the map means a full map
    always_comb begin
        len_norm_s = scan_len;
        if ((scan_len == LW'(0)) || (scan_len > DEPTH_L)) begin
            len_norm_s = DEPTH_L;
        end else begin
            len_norm_s = scan_len;
        end
    end

    // Beat address and border detection for the current raster position
    always_comb begin
        on_edge_s = (row_r == RW'(0)) || (row_r == EDGE_RC) ||
                    (col_r == RW'(0)) || (col_r == EDGE_RC);
        rd_addr_s = AW'(issued_r);
        if (pad_r) begin
            // Interior pixel (r,c) maps to (r-1)*IMG_W + (c-1); wraps on the
            // border are harmless because border beats are forced to zero.
            rd_addr_s = (AW'(row_r) - AW'(1)) * AW'(IMG_W) + (AW'(col_r) - AW'(1));
        end else begin
            rd_addr_s = AW'(issued_r);
        end
    end

    // Gather every channel at the beat address, zeroing padding beats
    always_comb begin
        beat_word_s = {(CH*DW){1'b0}};
        for (int g = 0; g < CH; g++) begin
            beat_word_s[g*DW +: DW] = mem_r[g][rd_addr_s];
        end
        if (pad_r && on_edge_s) begin
            beat_data_s = {(CH*DW){1'b0}};
        end else begin
            beat_data_s = beat_word_s;
        end
    end

    // Handshake qualifiers for the output register and the bank write port
    always_comb begin
        load_beat_s  = (state_r == ST_SCAN) && (issued_r < total_r) &&
                       (!rd_valid_r || rd_ready);
        final_beat_s = (issued_r == (total_r - BW'(1)));
        wr_en_s      = (state_r == ST_LOAD) && ld_valid && ld_ready_r && !rst;
    end

    // Bank storage: written only by accepted load words, never reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[ch_cnt_r][addr_cnt_r] <= ld_data;
        end
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ch_cnt_r    <= CW'(0);
            addr_cnt_r  <= AW'(0);
            pad_r       <= 1'b0;
            total_r     <= BW'(0);
            issued_r    <= BW'(0);
            row_r       <= RW'(0);
            col_r       <= RW'(0);
            ld_ready_r  <= 1'b0;
            ld_done_r   <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= {(CH*DW){1'b0}};
            rd_last_r   <= 1'b0;
            scan_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ld_done_r   <= 1'b0;
            scan_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A simultaneous scan_start is dropped in favour of the load
                    if (load_start) begin
                        state_r    <= ST_LOAD;
                        busy_r     <= 1'b1;
                        ld_ready_r <= 1'b1;
                        ch_cnt_r   <= CW'(0);
                        addr_cnt_r <= AW'(0);
                    end else if (scan_start) begin
                        state_r  <= ST_SCAN;
                        busy_r   <= 1'b1;
                        pad_r    <= pad_en;
                        total_r  <= pad_en ? NPAD_B : BW'(len_norm_s);
                        issued_r <= BW'(0);
                        row_r    <= RW'(0);
                        col_r    <= RW'(0);
                    end
                end
                ST_LOAD: begin
                    if (ld_valid && ld_ready_r) begin
                        if (addr_cnt_r == LAST_ADDR) begin
                            addr_cnt_r <= AW'(0);
                            if (ch_cnt_r == LAST_CH) begin
                                ch_cnt_r   <= CW'(0);
                                ld_ready_r <= 1'b0;
                                ld_done_r  <= 1'b1;
                                busy_r     <= 1'b0;
                                state_r    <= ST_IDLE;
                            end else begin
                                ch_cnt_r <= ch_cnt_r + CW'(1);
                            end
                        end else begin
                            addr_cnt_r <= addr_cnt_r + AW'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    if (load_beat_s) begin
                        rd_valid_r <= 1'b1;
                        rd_data_r  <= beat_data_s;
                        rd_last_r  <= final_beat_s;
                        issued_r   <= issued_r + BW'(1);
                        if (pad_r) begin
                            if (col_r == EDGE_RC) begin
                                col_r <= RW'(0);
                                row_r <= row_r + RW'(1);
                            end else begin
                                col_r <= col_r + RW'(1);
                            end
                        end
                    end else if (rd_valid_r && rd_ready) begin
                        // Only reachable when no beats remain to refill the register
                        rd_valid_r <= 1'b0;
                        rd_last_r  <= 1'b0;
                        if (rd_last_r) begin
                            scan_done_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    ld_ready_r <= 1'b0;
                    rd_valid_r <= 1'b0;
                    rd_last_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_buf_bank.sv
// ---------------------------------------------------------------------------
// tb_layer_buf_bank
// Self-checking bench for layer_buf_bank (CH=2, IMG_W=4, DW=16).
// A transaction-level model (map contents plus a queue of expected beats)
// is checked against the DUT on every falling edge; the driver adds a few
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_layer_buf_bank;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int IMG_W = 4;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_SCAN = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_start = 1'b0;
    logic               ld_valid = 1'b0;
    logic signed [15:0] ld_data = 16'sd0;
    logic               ld_ready;
    logic               ld_done;
    logic               scan_start = 1'b0;
    logic [4:0]         scan_len = 5'd0;
    logic               pad_en = 1'b0;
    logic               rd_valid;
    logic               rd_ready = 1'b0;
    logic [31:0]        rd_data;
    logic               rd_last;
    logic               scan_done;
    logic               busy;

    int errors = 0;
    int checks = 0;

    // model state
    logic [15:0] mmem [2][16];
    logic [31:0] exp_q [$];
    logic [31:0] cap [$];
    int  m_phase = P_IDLE;
    int  ld_k = 0;
    bit  entry = 1'b0;
    bit  ld_done_due = 1'b0;
    bit  scan_done_due = 1'b0;
    bit  zero_due = 1'b1;
    bit  chk_en = 1'b0;
    logic exp_valid;

    layer_buf_bank #(.DW(DW), .CH(CH), .IMG_W(IMG_W)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .scan_start(scan_start), .scan_len(scan_len), .pad_en(pad_en),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .scan_done(scan_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Expected beat list for a scan, straight from the map geometry
    function automatic void build_scan(input logic [4:0] len, input logic pad);
        int l;
        int a;
        exp_q.delete();
        if (pad) begin
            for (int r = 0; r < IMG_W + 2; r++) begin
                for (int c = 0; c < IMG_W + 2; c++) begin
                    if (r == 0 || c == 0 || r == IMG_W + 1 || c == IMG_W + 1) begin
                        exp_q.push_back(32'h0);
                    end else begin
                        a = (r - 1) * IMG_W + (c - 1);
                        exp_q.push_back({mmem[1][a], mmem[0][a]});
                    end
                end
            end
        end else begin
            l = (len == 5'd0 || int'(len) > 16) ? 16 : int'(len);
            for (int i = 0; i < l; i++) exp_q.push_back({mmem[1][i], mmem[0][i]});
        end
    endfunction

    // Compare outputs against the model, then advance the model one cycle
    always @(negedge clk) begin
        exp_valid = (m_phase == P_SCAN) && !entry && (exp_q.size() > 0);
        if (chk_en) begin
            chk("busy", busy, m_phase != P_IDLE);
            chk("ld_ready", ld_ready, m_phase == P_LOAD);
            chk("ld_done", ld_done, ld_done_due);
            chk("scan_done", scan_done, scan_done_due);
            chk("rd_valid", rd_valid, exp_valid);
            if (exp_valid && rd_valid) begin
                chk("rd_data", rd_data, exp_q[0]);
                chk("rd_last", rd_last, exp_q.size() == 1);
            end else begin
                chk("rd_last_idle", rd_last, 1'b0);
                if (zero_due) chk("rd_data_reset", rd_data, 32'h0);
            end
        end
        if (exp_valid) zero_due = 1'b0;
        ld_done_due = 1'b0;
        scan_done_due = 1'b0;
        if (rst) begin
            m_phase = P_IDLE;
            exp_q.delete();
            entry = 1'b0;
            ld_k = 0;
            zero_due = 1'b1;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (load_start) begin
                        m_phase = P_LOAD;
                        ld_k = 0;
                    end else if (scan_start) begin
                        build_scan(scan_len, pad_en);
                        m_phase = P_SCAN;
                        entry = 1'b1;
                    end
                end
                P_LOAD: begin
                    if (ld_valid) begin
                        mmem[ld_k / 16][ld_k % 16] = ld_data;
                        ld_k++;
                        if (ld_k == 32) begin
                            m_phase = P_IDLE;
                            ld_done_due = 1'b1;
                        end
                    end
                end
                P_SCAN: begin
                    if (entry) begin
                        entry = 1'b0;
                    end else if (exp_q.size() > 0 && rd_ready) begin
                        cap.push_back(rd_data);
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            m_phase = P_IDLE;
                            scan_done_due = 1'b1;
                        end
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial load of 32 words; optional reset abort after abort_at words
    task automatic do_load(input bit rnd, input int abort_at, input bit both);
        int k = 0;
        int cyc = 0;
        bit acc;
        load_start = 1'b1;
        scan_start = both;
        tick();
        load_start = 1'b0;
        scan_start = 1'b0;
        if (both) chk("both_starts_load", ld_ready, 1'b1);
        while (k < 32 && cyc < 1000) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data = rnd ? 16'($urandom) : 16'(k);
            if (abort_at >= 0 && k == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                ld_valid = 1'b0;
                chk("load_abort_ready", ld_ready, 1'b0);
                chk("load_abort_busy", busy, 1'b0);
                return;
            end
            acc = ld_valid && ld_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        ld_valid = 1'b0;
        if (k < 32) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: actual=%0d words expected=32 words", k);
        end
        chk("ld_done_latency", ld_done, 1'b1);
        chk("ld_ready_after", ld_ready, 1'b0);
    endtask

    // One scan; rst_at >= 0 resets while beat rst_at is presented
    task automatic do_scan(input logic [4:0] len, input bit pad, input bit rnd_ready,
                           input int rst_at, output int nbeats, output int mdl_n);
        int n = 0;
        int cyc = 0;
        bit done = 1'b0;
        cap.delete();
        scan_len = len;
        pad_en = pad;
        rd_ready = 1'b1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        mdl_n = exp_q.size();
        chk("first_valid_t1", rd_valid, 1'b0);
        while (!done && cyc < 500) begin
            rd_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rd_valid && !rd_last) begin
                load_start = ($urandom_range(0, 7) == 0);
                scan_start = ($urandom_range(0, 7) == 0);
            end
            if (rst_at >= 0 && rd_valid && n == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                load_start = 1'b0;
                scan_start = 1'b0;
                chk("rst_mid_scan_valid", rd_valid, 1'b0);
                chk("rst_mid_scan_busy", busy, 1'b0);
                done = 1'b1;
            end else begin
                if (rd_valid && rd_ready) n++;
                tick();
                load_start = 1'b0;
                scan_start = 1'b0;
                if (cyc == 0) chk("first_valid_t2", rd_valid, 1'b1);
                if (scan_done) done = 1'b1;
            end
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: actual=no scan_done expected=scan_done");
        end
        nbeats = n;
    endtask

    initial begin
        int nb;
        int mn;
        // reset held two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            load_start = 1'($urandom);
            scan_start = 1'($urandom);
            ld_valid = 1'($urandom);
            ld_data = 16'($urandom);
            rd_ready = 1'($urandom);
            scan_len = 5'($urandom);
            pad_en = 1'($urandom);
            tick();
        end
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_ld_ready", ld_ready, 1'b0);
        chk("reset_ld_done", ld_done, 1'b0);
        chk("reset_rd_last", rd_last, 1'b0);
        chk("reset_scan_done", scan_done, 1'b0);
        chk("reset_busy", busy, 1'b0);
        load_start = 1'b0;
        scan_start = 1'b0;
        ld_valid = 1'b0;
        rd_ready = 1'b0;
        scan_len = 5'd0;
        pad_en = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // load words 0..31 with load_start and scan_start together
        do_load(1'b0, -1, 1'b1);
        tick();

        // plain scan of 16 beats
        do_scan(5'd16, 1'b0, 1'b0, -1, nb, mn);
        chk("plain_model_len", mn, 16);
        chk("plain_beats", nb, 16);
        chk("plain_beat0", cap[0], 32'h0010_0000);
        chk("plain_beat15", cap[15], 32'h001f_000f);

        // padded scan, always ready
        do_scan(5'd3, 1'b1, 1'b0, -1, nb, mn);
        chk("pad_model_len", mn, 36);
        chk("pad_beats", nb, 36);
        for (int i = 0; i < 7; i++) chk("pad_zero_lead", cap[i], 32'h0);
        chk("pad_beat7", cap[7], 32'h0010_0000);
        chk("pad_beat10", cap[10], 32'h0013_0003);
        chk("pad_beat11", cap[11], 32'h0);

        // padded scan with random backpressure and stray start pulses
        do_scan(5'd9, 1'b1, 1'b1, -1, nb, mn);
        chk("bp_beats", nb, 36);
        chk("bp_beat28", cap[28], 32'h001f_000f);
        chk("bp_beat35", cap[35], 32'h0);

        // length corner cases
        do_scan(5'd0, 1'b0, 1'b1, -1, nb, mn);
        chk("len0_beats", nb, 16);
        do_scan(5'd20, 1'b0, 1'b1, -1, nb, mn);
        chk("len20_beats", nb, 16);
        do_scan(5'd5, 1'b0, 1'b1, -1, nb, mn);
        chk("len5_beats", nb, 5);
        chk("len5_last", cap[4], 32'h0014_0004);

        // reset at beat 5, then rescan sees unchanged data
        do_scan(5'd16, 1'b0, 1'b0, 5, nb, mn);
        tick();
        do_scan(5'd16, 1'b0, 1'b0, -1, nb, mn);
        chk("rescan_beats", nb, 16);
        chk("rescan_beat5", cap[5], 32'h0015_0005);

        // aborted load, then a full random load checked by padded scans
        do_load(1'b1, 10, 1'b0);
        tick();
        do_load(1'b1, -1, 1'b0);
        tick();
        do_scan(5'd0, 1'b1, 1'b1, -1, nb, mn);
        chk("rand_pad_beats", nb, 36);
        do_scan(5'd11, 1'b0, 1'b1, -1, nb, mn);
        chk("rand_len11_beats", nb, 11);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_buf_bank.md
LAYER_BUF_BANK -- requirements
Module: layer_buf_bank

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed data word width.
REQ-002 SHALL have parameter CH, default 6, meaning channel (feature-map) count.
REQ-003 SHALL have parameter IMG_W, default 8, meaning square map side; localparam DEPTH = IMG_W*IMG_W words per channel.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port load_start, input, 1, pulse that begins a serial load.
REQ-007 SHALL have port ld_valid, input, 1, ld_data qualifier.
REQ-008 SHALL have port ld_data, input, DW, signed load word.
REQ-009 SHALL have port ld_ready, output, 1, bank accepts load words.
REQ-010 SHALL have port ld_done, output, 1, one-cycle pulse at load completion.
REQ-011 SHALL have port scan_start, input, 1, pulse that begins a read scan.
REQ-012 SHALL have port scan_len, input, clog2(DEPTH)+1, beat count for unpadded scan; sampled at scan_start.
REQ-013 SHALL have port pad_en, input, 1, zero-padding mode select; sampled at scan_start.
REQ-014 SHALL have port rd_valid, output, 1, rd_data qualifier.
REQ-015 SHALL have port rd_ready, input, 1, downstream accept.
REQ-016 SHALL have port rd_data, output, CH*DW, all channels at one address, channel 0 in LSBs.
REQ-017 SHALL have port rd_last, output, 1, marks final beat of a scan.
REQ-018 SHALL have port scan_done, output, 1, one-cycle pulse at scan completion.
REQ-019 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-020 SHALL implement states IDLE, LOAD, SCAN.
REQ-021 In IDLE, load_start SHALL move to LOAD next cycle; scan_start SHALL move to SCAN; if both are asserted, LOAD wins and scan_start is dropped.
REQ-022 Start pulses arriving in LOAD or SCAN SHALL be ignored.
REQ-023 In LOAD, ld_ready SHALL be 1; each ld_valid&&ld_ready cycle writes ld_data to channel ch_cnt, address addr_cnt.
REQ-024 addr_cnt SHALL wrap DEPTH-1 to 0 and increment ch_cnt; word k lands in channel k/DEPTH, address k%DEPTH.
REQ-025 After the CH*DEPTH-th accepted word, the block SHALL pulse ld_done the next cycle, drop ld_ready, and return to IDLE.
REQ-026 In SCAN with pad_en=0, beats SHALL read addresses 0..L-1, with L=scan_len; scan_len=0 or scan_len>DEPTH SHALL be treated as DEPTH.
REQ-027 In SCAN with pad_en=1, the block SHALL emit (IMG_W+2)^2 beats in raster order over row r and column c, each 0..IMG_W+1.
REQ-028 A pad_en=1 beat with r or c equal to 0 or IMG_W+1 SHALL output all-zero rd_data; otherwise it SHALL output address (r-1)*IMG_W+(c-1).
REQ-029 The output register SHALL load a new beat when (!rd_valid || rd_ready) and beats remain; rd_data, rd_last and rd_valid SHALL stay stable while rd_valid&&!rd_ready.
REQ-030 With rd_ready held high, scan_start in cycle T SHALL give the first rd_valid in cycle T+2, followed by one beat per cycle.
REQ-031 rd_last SHALL be 1 only with the final beat.
REQ-032 Acceptance of the final beat SHALL clear rd_valid, pulse scan_done next cycle, and return to IDLE.
REQ-033 No beat SHALL be dropped or duplicated under any rd_ready pattern.

Reset
REQ-034 rst SHALL force IDLE and clear all counters; ld_ready, ld_done, rd_valid, rd_last, scan_done and busy SHALL be 0, and rd_data SHALL be 0.
REQ-035 rst asserted mid-LOAD or mid-SCAN SHALL abort the operation, with outputs at reset values the next cycle.
REQ-036 Memory contents SHALL NOT be cleared by rst.

Verification (CH=2, IMG_W=4, DW=16)
REQ-037 Reset: hold rst 2 cycles with random inputs -> all outputs 0, busy=0.
REQ-038 Load: load_start, then words 0..31 with random ld_valid gaps -> ld_done one cycle after the 32nd accept; later scans read ch0=0..15 and ch1=16..31.
REQ-039 Plain scan: pad_en=0, scan_len=16, rd_ready=1 -> beats k=0..15 carry rd_data={16+k,k}, first beat at T+2, rd_last on k=15, scan_done next cycle.
REQ-040 Padded scan: pad_en=1 -> 36 beats; beats 0..6 are zero; beat 7={16,0}; beat 10={19,3}; beat 11=0; rd_last on beat 35.
REQ-041 Backpressure: random rd_ready during a padded scan -> data stable while stalled, exactly 36 accepted beats in order.
REQ-042 Corner cases:
- load_start and scan_start in the same IDLE cycle -> LOAD.
- scan_len=0 -> 16 beats.
- rst at beat 5 of a scan -> rd_valid=0 next cycle; a rescan returns the loaded data unchanged.
